// File: rtl/alu_pkg.sv
// Shared ALU arbiter definitions: opcodes, FSM state type, default operand width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [3:0] COP_ZERO  = 4'd0;
  localparam logic [3:0] COP_ADD   = 4'd1;
  localparam logic [3:0] COP_SUB   = 4'd2;
  localparam logic [3:0] COP_PASSB = 4'd3;
  localparam logic [3:0] COP_EQ    = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcode and issuing requester travel together from accept to response.
  typedef struct packed {
    logic [3:0] cop;
    logic       id;
  } op_tag_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: zero, add, subtract, pass B, equality, with carry/borrow and bad-opcode flag.
// Latency: purely combinational; the caller registers the outputs.
// Backpressure: none; operands are held stable by the caller's registers.
module alu
  import alu_pkg::*;
#(
  parameter int INPUT_WIDTH = DEF_WIDTH
) (
  input  logic [INPUT_WIDTH-1:0] a_i,
  input  logic [INPUT_WIDTH-1:0] b_i,
  input  logic [3:0]             cop_i,
  output logic [INPUT_WIDTH-1:0] result_o,
  output logic                   ovf_o,
  output logic                   err_o
);

  // One extra bit so the carry of an add and the borrow of a subtract land in the MSB.
  logic [INPUT_WIDTH:0] a_ext;
  logic [INPUT_WIDTH:0] b_ext;
  logic [INPUT_WIDTH:0] sum_ext;
  logic [INPUT_WIDTH:0] diff_ext;

  assign a_ext    = {1'b0, a_i};
  assign b_ext    = {1'b0, b_i};
  assign sum_ext  = a_ext + b_ext;
  assign diff_ext = a_ext - b_ext;

  // Opcode decode; unknown opcodes produce a clean zero result with the error flag.
  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    err_o    = 1'b0;
    case (cop_i)
      COP_ZERO:  result_o = '0;
      COP_ADD: begin
        result_o = sum_ext[INPUT_WIDTH-1:0];
        ovf_o    = sum_ext[INPUT_WIDTH];
      end
      COP_SUB: begin
        result_o = diff_ext[INPUT_WIDTH-1:0];
        ovf_o    = diff_ext[INPUT_WIDTH];
      end
      COP_PASSB: result_o = b_i;
      COP_EQ:    result_o[0] = (a_i == b_i);
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU, one operation in flight; ALU_ARB_RR_EN selects round-robin over fixed priority.
// Latency: accept in cycle T, response presented in T+2; one operation per 3 cycles when the consumer is always ready.
// Backpressure: response held stable until resp_ready; both request readies stay low until the response is taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int INPUT_WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [INPUT_WIDTH-1:0] req0_a,
  input  logic [INPUT_WIDTH-1:0] req0_b,
  input  logic [3:0]             req0_cop,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [INPUT_WIDTH-1:0] req1_a,
  input  logic [INPUT_WIDTH-1:0] req1_b,
  input  logic [3:0]             req1_cop,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [INPUT_WIDTH-1:0] resp_result,
  output logic                   resp_ovf,
  output logic                   resp_err
);

  state_t state_q, state_d;

  logic                   grant_id;
  logic                   hs;
  logic                   rdy0;
  logic                   rdy1;

  logic [INPUT_WIDTH-1:0] a_q, a_d;
  logic [INPUT_WIDTH-1:0] b_q, b_d;
  op_tag_t                tag_q, tag_d;

  logic [INPUT_WIDTH-1:0] res_q;
  logic                   ovf_q;
  logic                   err_q;

  logic [INPUT_WIDTH-1:0] alu_res;
  logic                   alu_ovf;
  logic                   alu_err;

`ifdef ALU_ARB_RR_EN
  // Requester that wins the next tie: always the one not granted last.
  logic ptr_q, ptr_d;

  // Tie goes to the pointer; a lone requester wins regardless of the pointer.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ptr_q;
    else                          grant_id = req1_valid;
  end

  assign ptr_d = hs ? ~grant_id : ptr_q;

  // Pointer moves only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    grant_id = ~req0_valid & req1_valid;
  end
`endif

  // Accept whenever idle and anyone is asking; the grant always points at a valid requester.
  assign hs = (state_q == ST_IDLE) && (req0_valid || req1_valid);

  // Operand capture mux for the granted requester.
  assign a_d   = grant_id ? req1_a : req0_a;
  assign b_d   = grant_id ? req1_b : req0_b;
  assign tag_d = '{cop: (grant_id ? req1_cop : req0_cop), id: grant_id};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: accept, one execute cycle, then hold the response until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: readies only while idle, response valid only in RESP.
  always_comb begin
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    resp_valid = (state_q == ST_RESP);
    if (state_q == ST_IDLE) begin
      rdy0 = req0_valid & ~grant_id;
      rdy1 = req1_valid & grant_id;
    end
  end

  // Readies are forced low while reset is held, even though the state already reads IDLE.
  assign req0_ready = rdy0 & rst_n;
  assign req1_ready = rdy1 & rst_n;

  // Capture the granted operation on accept; register ALU outputs in the execute cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (hs) begin
        a_q   <= a_d;
        b_q   <= b_d;
        tag_q <= tag_d;
      end
      if (state_q == ST_EXEC) begin
        res_q <= alu_res;
        ovf_q <= alu_ovf;
        err_q <= alu_err;
      end
    end
  end

  alu #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .cop_i   (tag_q.cop),
    .result_o(alu_res),
    .ovf_o   (alu_ovf),
    .err_o   (alu_err)
  );

  assign resp_id     = tag_q.id;
  assign resp_result = res_q;
  assign resp_ovf    = ovf_q;
  assign resp_err    = err_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: Parameter INPUT_WIDTH, default 16, SHALL set the operand and result width.
- REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  SHALL be the asynchronous, active-low reset.
- REQ-004: reqN_valid  input  1 (N=0,1)  SHALL mean requester N offers an operation.
- REQ-005: reqN_ready  output  1  SHALL mean requester N's operation is accepted this cycle.
- REQ-006: reqN_a, reqN_b  input  INPUT_WIDTH  SHALL carry operands A and B.
- REQ-007: reqN_cop  input  4  SHALL carry the opcode: 0 zero, 1 A+B, 2 A-B, 3 pass B, 4 A==B.
- REQ-008: resp_valid  output  1  SHALL mean a response is presented.
- REQ-009: resp_ready  input  1  SHALL mean the consumer takes the response this cycle.
- REQ-010: resp_id  output  1  SHALL identify the requester that issued the response.
- REQ-011: resp_result  output  INPUT_WIDTH  SHALL carry the ALU result.
- REQ-012: resp_ovf  output  1  SHALL carry the ALU carry/borrow bit (bit INPUT_WIDTH of the extended result).
- REQ-013: resp_err  output  1  SHALL flag an opcode above 4.

Function
- REQ-014: FSM SHALL have states IDLE, EXEC, RESP.
- REQ-015: In IDLE, reqN_ready SHALL be high only for the granted N, and only when that reqN_valid is high.
- REQ-016: On handshake (reqN_valid & reqN_ready), the block SHALL register a, b, cop, and id, then move to EXEC.
- REQ-017: In EXEC (one cycle), the registered operands SHALL drive the ALU, result/ovf/err SHALL be registered, and the FSM SHALL move to RESP.
- REQ-018: In RESP, resp_valid SHALL be high with stable outputs until resp_ready; on resp_ready the FSM SHALL return to IDLE.
- REQ-019: Latency: handshake in cycle T SHALL give resp_valid in T+2; back-to-back throughput SHALL be one operation per 3 cycles with resp_ready held high.
- REQ-020: Both ready outputs SHALL be low in EXEC and RESP (one operation in flight).
- REQ-021: Extended arithmetic SHALL use INPUT_WIDTH+1 bits: add carry-out sets ovf; A-B with A<B sets ovf=1 and result wraps modulo 2^INPUT_WIDTH.
- REQ-022: Compare SHALL return result 1 when A==B, else 0, with ovf 0.
- REQ-023: For cop>4, the block SHALL return resp_err=1, result 0, ovf 0, with no X propagated.
- REQ-024: With a single valid requester, that requester SHALL be granted whatever the arbitration pointer holds.

Reset
- REQ-025: Asserting rst_n low SHALL force IDLE, resp_valid 0, both ready 0, resp_result 0, resp_ovf 0, resp_err 0, resp_id 0, and point the arbitration pointer at requester 0, including mid-EXEC or mid-RESP.
- REQ-026: An operation interrupted by reset SHALL be discarded, with no response issued.

Configuration
- REQ-027: With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: when both requesters are valid, the one not granted last SHALL win, and the pointer SHALL update only on handshake.
- REQ-028: Without ALU_ARB_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning a tie.

Structure
- REQ-029: Opcode constants (COP_ZERO..COP_EQ), the FSM state typedef, and the default width SHALL live in the shared package alu_pkg.
- REQ-030: The datapath SHALL be one instantiated sub-module, alu, parameterised by INPUT_WIDTH and driven only from the registered operands.

Verification
- REQ-031: req0 with a=16'h0003, b=16'h0004, cop=1 -> resp in T+2: result 16'h0007, ovf 0, id 0, err 0.
- REQ-032: req1 with a=16'hFFFF, b=16'h0001, cop=1 -> result 16'h0000, ovf 1, id 1.
- REQ-033: req0 with a=16'h0002, b=16'h0005, cop=2 -> result 16'hFFFD, ovf 1; cop=4 with a=b=16'h1234 -> result 1.
- REQ-034: Both valid for 4 operations with RR enabled -> ids 0,1,0,1; with RR disabled -> ids 0,0,0,0.
- REQ-035: resp_ready held low 5 cycles -> resp_valid and its data stable, both ready low; then release -> IDLE and the next grant.
- REQ-036: cop=4'hF -> err 1, result 0; rst_n pulsed low during EXEC -> all outputs 0, no response, req0 granted first afterwards.
